// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU memory stage and the data memory.
// req_be exists only when DMEM_BYTE_ENABLE_EN is defined.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
`ifdef DMEM_BYTE_ENABLE_EN
   logic [3:0]  req_be;
`endif
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid,
      input  req_ready,
      output req_write,
      output req_addr,
      output req_wdata,
`ifdef DMEM_BYTE_ENABLE_EN
      output req_be,
`endif
      input  rsp_valid,
      output rsp_ready,
      input  rsp_rdata,
      input  rsp_err
   );

   modport slave (
      input  req_valid,
      output req_ready,
      input  req_write,
      input  req_addr,
      input  req_wdata,
`ifdef DMEM_BYTE_ENABLE_EN
      input  req_be,
`endif
      output rsp_valid,
      input  rsp_ready,
      output rsp_rdata,
      output rsp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed-latency response FSM.
// Optional byte-lane stores: define DMEM_BYTE_ENABLE_EN.
module data_mem_responder #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   data_mem_responder_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WAIT_INIT =
      4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [3:0]  cnt;
   logic [3:0]  next_cnt;

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;
   logic        err_q;

   logic [29:0]   idx;
   logic [AW-1:0] widx;
   logic          bad_align;
   logic          bad_range;
   logic          req_err;
   logic          accept;

   assign idx       = bus.req_addr[31:2];
   assign widx      = idx[AW-1:0];
   assign bad_align = |bus.req_addr[1:0];
   assign bad_range = idx >= 30'(DEPTH);
`ifdef DMEM_BYTE_ENABLE_EN
   assign req_err   = bad_align | bad_range |
                      (bus.req_write & ~|bus.req_be);
`else
   assign req_err   = bad_align | bad_range;
`endif
   assign accept    = (state == IDLE) & bus.req_valid;

   // State and wait counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      unique case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  next_state = RESP;
               end else begin
                  next_state = WAIT;
                  next_cnt   = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               next_state = RESP;
            end else begin
               next_cnt = cnt - 4'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
            next_cnt   = 4'd0;
         end
      endcase
   end

   // Outputs: response fields are forced to zero outside RESP
   always_comb begin
      bus.req_ready = (state == IDLE);
      bus.rsp_valid = (state == RESP);
      bus.rsp_rdata = (state == RESP) ? rdata_q : 32'd0;
      bus.rsp_err   = (state == RESP) ? err_q : 1'b0;
   end

   // Capture the response at acceptance; held until the next acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else if (accept) begin
         err_q   <= req_err;
         rdata_q <= (req_err | bus.req_write) ? 32'd0 : mem[widx];
      end
   end

   // Store commit at acceptance; contents survive reset
   always_ff @(posedge clk) begin
      if (rst_n && accept && bus.req_write && !req_err) begin
`ifdef DMEM_BYTE_ENABLE_EN
         for (int i = 0; i < 4; i++) begin
            if (bus.req_be[i]) begin
               mem[widx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
         end
`else
         mem[widx] <= bus.req_wdata;
`endif
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// dut0: WAIT_CYCLES=2, dut1: WAIT_CYCLES=0 back-to-back.
module tb_data_mem_responder;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   data_mem_responder_if bus0 ();
   data_mem_responder_if bus1 ();

`ifdef DMEM_BYTE_ENABLE_EN
   logic [3:0] cur_be;
   assign bus0.req_be = cur_be;
   assign bus1.req_be = 4'hF;
`endif

   data_mem_responder #(
      .DEPTH       (64),
      .WAIT_CYCLES (2)
   ) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   data_mem_responder #(
      .DEPTH       (64),
      .WAIT_CYCLES (0)
   ) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w,
                        input logic [31:0] a,
                        input logic [31:0] d);
      bus0.req_valid = 1'b1;
      bus0.req_write = w;
      bus0.req_addr  = a;
      bus0.req_wdata = d;
   endtask

   // Full transaction on dut0 with latency and release checks
   task automatic req0(input string tag,
                       input logic w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [31:0] exp_rd,
                       input logic exp_err);
      drive(w, a, d);
      chk({tag, "_ready"}, 32'(bus0.req_ready), 32'd1);
      step();
      bus0.req_valid = 1'b0;
      chk({tag, "_v0"}, 32'(bus0.rsp_valid), 32'd0);
      chk({tag, "_rd0"}, bus0.rsp_rdata, 32'd0);
      step();
      chk({tag, "_v1"}, 32'(bus0.rsp_valid), 32'd0);
      step();
      chk({tag, "_v2"}, 32'(bus0.rsp_valid), 32'd1);
      chk({tag, "_rdata"}, bus0.rsp_rdata, exp_rd);
      chk({tag, "_err"}, 32'(bus0.rsp_err), 32'(exp_err));
      bus0.rsp_ready = 1'b1;
      step();
      bus0.rsp_ready = 1'b0;
      chk({tag, "_done_v"}, 32'(bus0.rsp_valid), 32'd0);
      chk({tag, "_done_rdy"}, 32'(bus0.req_ready), 32'd1);
      chk({tag, "_done_err"}, 32'(bus0.rsp_err), 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
`ifdef DMEM_BYTE_ENABLE_EN
      cur_be = 4'hF;
`endif
      bus0.req_valid = 1'b0;
      bus0.req_write = 1'b0;
      bus0.req_addr  = 32'd0;
      bus0.req_wdata = 32'd0;
      bus0.rsp_ready = 1'b0;
      bus1.req_valid = 1'b0;
      bus1.req_write = 1'b0;
      bus1.req_addr  = 32'd0;
      bus1.req_wdata = 32'd0;
      bus1.rsp_ready = 1'b1;

      // Reset state
      #2 rst_n = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(bus0.rsp_valid), 32'd0);
      chk("rst_rdata", bus0.rsp_rdata, 32'd0);
      chk("rst_err", 32'(bus0.rsp_err), 32'd0);
      rst_n = 1'b1;
      step();
      chk("rst_ready", 32'(bus0.req_ready), 32'd1);
      chk("rst_ready1", 32'(bus1.req_ready), 32'd1);

      // Store then load
      req0("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
      req0("ld10", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

      // Error cases; out-of-range store must not alias word 0
      req0("st00", 1'b1, 32'h0, 32'h12345678, 32'd0, 1'b0);
      req0("ld12", 1'b0, 32'h12, 32'd0, 32'd0, 1'b1);
      req0("ld100", 1'b0, 32'h100, 32'd0, 32'd0, 1'b1);
      req0("st100", 1'b1, 32'h100, 32'hFFFFFFFF, 32'd0, 1'b1);
      req0("ld00", 1'b0, 32'h0, 32'd0, 32'h12345678, 1'b0);
      req0("ldfc", 1'b0, 32'hFC, 32'd0, 32'd0, 1'b0);

      // Backpressure in RESP; new requests ignored meanwhile
      drive(1'b0, 32'h10, 32'd0);
      step();
      bus0.req_valid = 1'b0;
      step();
      step();
      drive(1'b1, 32'h10, 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(bus0.rsp_valid), 32'd1);
         chk("hold_rdata", bus0.rsp_rdata, 32'hDEADBEEF);
         chk("hold_err", 32'(bus0.rsp_err), 32'd0);
         chk("hold_ready", 32'(bus0.req_ready), 32'd0);
         step();
      end
      bus0.req_valid = 1'b0;
      bus0.rsp_ready = 1'b1;
      step();
      bus0.rsp_ready = 1'b0;
      chk("hold_rel_v", 32'(bus0.rsp_valid), 32'd0);
      chk("hold_rel_rdy", 32'(bus0.req_ready), 32'd1);
      req0("ld10b", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

      // Reset during WAIT after a store and after a load
      drive(1'b1, 32'h44, 32'h0BADC0DE);
      step();
      bus0.req_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      chk("rstw_st_v", 32'(bus0.rsp_valid), 32'd0);
      chk("rstw_st_rdy", 32'(bus0.req_ready), 32'd1);
      step();
      rst_n = 1'b1;
      drive(1'b0, 32'h10, 32'd0);
      step();
      bus0.req_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      chk("rstw_ld_v", 32'(bus0.rsp_valid), 32'd0);
      chk("rstw_ld_rd", bus0.rsp_rdata, 32'd0);
      chk("rstw_ld_rdy", 32'(bus0.req_ready), 32'd1);
      step();
      rst_n = 1'b1;
      step();
      chk("rstw_after_v", 32'(bus0.rsp_valid), 32'd0);
      step();
      chk("rstw_after_v2", 32'(bus0.rsp_valid), 32'd0);
      req0("ld44", 1'b0, 32'h44, 32'd0, 32'h0BADC0DE, 1'b0);

      // Zero-wait instance: one acceptance every two edges
      bus1.req_valid = 1'b1;
      bus1.req_write = 1'b1;
      bus1.req_addr  = 32'h8;
      bus1.req_wdata = 32'h55AA55AA;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("b2b_valid", 32'(bus1.rsp_valid), 32'((i % 2) == 0));
         chk("b2b_ready", 32'(bus1.req_ready), 32'((i % 2) != 0));
         chk("b2b_err", 32'(bus1.rsp_err), 32'd0);
      end
      bus1.req_write = 1'b0;
      step();
      chk("b2b_ld_v", 32'(bus1.rsp_valid), 32'd1);
      chk("b2b_ld_rd", bus1.rsp_rdata, 32'h55AA55AA);
      bus1.req_valid = 1'b0;
      step();
      chk("b2b_end_v", 32'(bus1.rsp_valid), 32'd0);
      chk("b2b_end_rd", bus1.rsp_rdata, 32'd0);

`ifdef DMEM_BYTE_ENABLE_EN
      // Byte-lane stores
      cur_be = 4'hF;
      req0("be_full", 1'b1, 32'h30, 32'h11223344, 32'd0, 1'b0);
      cur_be = 4'b0011;
      req0("be_low", 1'b1, 32'h30, 32'hAABBCCDD, 32'd0, 1'b0);
      cur_be = 4'hF;
      req0("be_ld", 1'b0, 32'h30, 32'd0, 32'h1122CCDD, 1'b0);
      cur_be = 4'h0;
      req0("be_zero", 1'b1, 32'h30, 32'h0, 32'd0, 1'b1);
      req0("be_ld2", 1'b0, 32'h30, 32'd0, 32'h1122CCDD, 1'b0);
      cur_be = 4'hF;
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
